// File: rtl/piso_shift_tx_pkg.sv
// Shared definitions for the piso_shift_tx transmitter: FSM state encoding and
// the bit-counter width helper.
package piso_shift_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Counter width for a WIDTH-bit word; at least one bit even for WIDTH=2.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_shift_tx_bit_counter.sv
// Modulo-WIDTH up-counter with enable, synchronous clear and a terminal-count
// flag qualified by the enable, used as the end-of-word indication.
module piso_shift_tx_bit_counter #(
    parameter int WIDTH = 4,
    parameter int CW    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] ZERO = CW'(0);

    logic [CW-1:0] cnt_r;

    assign tc = en && (cnt_r == LAST);

    // Count bit positions while enabled; wrap to zero after the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= ZERO;
        end else if (clr) begin
            cnt_r <= ZERO;
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_r <= ZERO;
            end else begin
                cnt_r <= cnt_r + ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and end-of-word pulse.
// Define PISO_TX_BACK_TO_BACK_EN to accept the next word during the last-bit cycle.
module piso_shift_tx
    import piso_shift_tx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_r;
    state_e           state_nx_s;
    logic [WIDTH-1:0] sreg_r;
    logic [WIDTH-1:0] sreg_nx_s;
    logic             ready_s;
    logic             accept_s;
    logic             done_s;
    logic             shifting_s;
    logic             out_s;

    assign shifting_s = (state_r == ST_SHIFT);

`ifdef PISO_TX_BACK_TO_BACK_EN
    assign ready_s = (state_r == ST_IDLE) || done_s;
`else
    assign ready_s = (state_r == ST_IDLE);
`endif

    assign accept_s = load && ready_s;

    piso_shift_tx_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .en  (shifting_s),
        .clr (accept_s),
        .tc  (done_s)
    );

    // Next-state and shift-register update; an accepted word overrides the shift.
    always_comb begin
        state_nx_s = state_r;
        sreg_nx_s  = sreg_r;
        case (state_r)
            ST_SHIFT: begin
                if (MSB_FIRST != 0) begin
                    sreg_nx_s = {sreg_r[WIDTH-2:0], 1'b0};
                end else begin
                    sreg_nx_s = {1'b0, sreg_r[WIDTH-1:1]};
                end
                if (done_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_IDLE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
        if (accept_s) begin
            sreg_nx_s  = din;
            state_nx_s = ST_SHIFT;
        end else begin
            sreg_nx_s = sreg_nx_s;
        end
    end

    // State and shift register, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            sreg_r  <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_nx_s;
            sreg_r  <= sreg_nx_s;
        end
    end

    // Serial bit is forced low outside a word.
    always_comb begin
        out_s = 1'b0;
        if (shifting_s) begin
            if (MSB_FIRST != 0) begin
                out_s = sreg_r[WIDTH-1];
            end else begin
                out_s = sreg_r[0];
            end
        end else begin
            out_s = 1'b0;
        end
    end

    assign ready     = ready_s;
    assign out       = out_s;
    assign out_valid = shifting_s;
    assign busy      = shifting_s;
    assign done      = done_s;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Randomized and directed bench for piso_shift_tx (MSB-first and LSB-first
// instances) against a queue-based model of the serial bit stream.
module tb_piso_shift_tx;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] din;

    logic ready_m, out_m, out_valid_m, busy_m, done_m;
    logic ready_l, out_l, out_valid_l, busy_l, done_l;

    int n_chk;
    int n_fail;

    logic             qm[$];
    logic             ql[$];
    logic [WIDTH-1:0] wordq[$];
    logic [WIDTH-1:0] sipo_m;
    logic [WIDTH-1:0] sipo_l;

    piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(1)) u_dut_msb (
        .clk(clk), .rst(rst), .load(load), .din(din),
        .ready(ready_m), .out(out_m), .out_valid(out_valid_m),
        .busy(busy_m), .done(done_m)
    );

    piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(0)) u_dut_lsb (
        .clk(clk), .rst(rst), .load(load), .din(din),
        .ready(ready_l), .out(out_l), .out_valid(out_valid_l),
        .busy(busy_l), .done(done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // A word may be accepted when nothing is in flight (or on its last bit).
    function automatic logic exp_ready();
`ifdef PISO_TX_BACK_TO_BACK_EN
        return (qm.size() <= 1);
`else
        return (qm.size() == 0);
`endif
    endfunction

    task automatic model_edge(input logic r, input logic l, input logic [WIDTH-1:0] d);
        logic acc;
        acc = l && exp_ready();
        if (r) begin
            qm.delete();
            ql.delete();
            wordq.delete();
        end else begin
            if (qm.size() == 1) void'(wordq.pop_front());
            if (qm.size() != 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (acc) begin
                for (int i = WIDTH - 1; i >= 0; i--) qm.push_back(d[i]);
                for (int i = 0; i < WIDTH; i++) ql.push_back(d[i]);
                wordq.push_back(d);
            end
        end
    endtask

    task automatic check_all();
        logic act;
        act = (qm.size() != 0);
        chk("ready_msb", ready_m, exp_ready());
        chk("valid_msb", out_valid_m, act);
        chk("busy_msb", busy_m, act);
        chk("out_msb", out_m, act ? qm[0] : 1'b0);
        chk("done_msb", done_m, qm.size() == 1);
        chk("ready_lsb", ready_l, exp_ready());
        chk("valid_lsb", out_valid_l, act);
        chk("busy_lsb", busy_l, act);
        chk("out_lsb", out_l, act ? ql[0] : 1'b0);
        chk("done_lsb", done_l, ql.size() == 1);
        if (out_valid_m) sipo_m = {sipo_m[WIDTH-2:0], out_m};
        if (out_valid_l) sipo_l = {out_l, sipo_l[WIDTH-1:1]};
        if (qm.size() == 1 && wordq.size() != 0) begin
            chk("sipo_msb", sipo_m, wordq[0]);
            chk("sipo_lsb", sipo_l, wordq[0]);
        end
    endtask

    task automatic cycle(input logic r, input logic l, input logic [WIDTH-1:0] d);
        rst  = r;
        load = l;
        din  = d;
        model_edge(r, l, d);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        sipo_m = '0;
        sipo_l = '0;
        rst    = 1'b1;
        load   = 1'b0;
        din    = '0;

        // reset for two cycles, then idle
        cycle(1'b1, 1'b0, 4'b0000);
        cycle(1'b1, 1'b0, 4'b0000);
        cycle(1'b0, 1'b0, 4'b0000);

        // single word 1010
        cycle(1'b0, 1'b1, 4'b1010);
        repeat (5) cycle(1'b0, 1'b0, 4'b0000);

        // load while busy is ignored
        cycle(1'b0, 1'b1, 4'b0011);
        cycle(1'b0, 1'b0, 4'b0000);
        cycle(1'b0, 1'b1, 4'b1111);
        repeat (4) cycle(1'b0, 1'b0, 4'b0000);

        // reset in the second bit cycle
        cycle(1'b0, 1'b1, 4'b1111);
        cycle(1'b0, 1'b0, 4'b0000);
        cycle(1'b1, 1'b0, 4'b0000);
        repeat (3) cycle(1'b0, 1'b0, 4'b0000);

        // load held high across two words
        cycle(1'b0, 1'b1, 4'b0011);
        repeat (9) cycle(1'b0, 1'b1, 4'b1111);
        repeat (5) cycle(1'b0, 1'b0, 4'b0000);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1),
                  WIDTH'($urandom()));
        end
        repeat (6) cycle(1'b0, 1'b0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
